// File: rtl/snn_pkg.sv
// Shared types and constants for the digit-classifier sequencer.
package snn_pkg;

   typedef enum logic [3:0] {
      StLoad   = 4'd0,
      StUnpack = 4'd1,
      StStart  = 4'd2,
      StRun    = 4'd3,
      StSend   = 4'd4,
      StWaitTx = 4'd5
   } seq_state_t;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_ERR   = 8'h45;

   localparam int unsigned NUM_BITS_C = 784;

   function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
      return (d <= 4'd9) ? (ASCII_ZERO + {4'd0, d}) : ASCII_QMARK;
   endfunction

endpackage

// File: rtl/snn_sequencer_byte_unpacker.sv
// Serialises one received byte LSB first and flags the eighth bit.
module byte_unpacker
   import snn_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] byte_in_i,
   input  logic       shift_i,
   output logic       bit_out_o,
   output logic       last_o
);

   logic [7:0] sr_q, sr_d;
   logic [2:0] bc_q, bc_d;

   always_comb begin
      sr_d = sr_q;
      bc_d = bc_q;
      if (load_i) begin
         sr_d = byte_in_i;
         bc_d = 3'd0;
      end else if (shift_i) begin
         sr_d = {1'b0, sr_q[7:1]};
         bc_d = bc_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q <= 8'd0;
         bc_q <= 3'd0;
      end else begin
         sr_q <= sr_d;
         bc_q <= bc_d;
      end
   end

   assign bit_out_o = sr_q[0];
   assign last_o    = (bc_q == 3'd7);

endmodule

// File: rtl/snn_sequencer.sv
// Frame loader, SNN core launcher and result transmitter; owns the input RAM port.
module snn_sequencer
   import snn_pkg::*;
#(
   parameter int unsigned NUM_BYTES = 98,
   parameter int unsigned NUM_BITS  = 8 * NUM_BYTES,
   parameter int unsigned TIMEOUT   = 32768
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_rdy_i,
   input  logic [7:0] rx_data_i,
   input  logic       tx_rdy_i,
   output logic       tx_start_o,
   output logic [7:0] tx_data_o,
   output logic [9:0] ram_addr_o,
   output logic       ram_d_o,
   output logic       ram_we_o,
   input  logic [9:0] core_addr_i,
   output logic       core_start_o,
   input  logic       core_done_i,
   input  logic [3:0] core_digit_i,
   output logic [3:0] digit_o,
   output logic       busy_o,
   output logic       err_o
);

   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
   localparam logic [9:0]    WpLast    = 10'(NUM_BITS - 1);

   seq_state_t    state_q, state_d;
   logic [9:0]    wp_q, wp_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    digit_q, digit_d;
   logic [7:0]    tx_byte_q, tx_byte_d;
   logic          err_q, err_d;
   logic          seen_low_q, seen_low_d;
   logic          load, shift, bit_out, last;

   byte_unpacker u_unpacker (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (load),
      .byte_in_i (rx_data_i),
      .shift_i   (shift),
      .bit_out_o (bit_out),
      .last_o    (last)
   );

   always_comb begin
      state_d      = state_q;
      wp_d         = wp_q;
      timer_d      = timer_q;
      digit_d      = digit_q;
      tx_byte_d    = tx_byte_q;
      err_d        = err_q;
      seen_low_d   = seen_low_q;
      load         = 1'b0;
      shift        = 1'b0;
      ram_addr_o   = wp_q;
      ram_d_o      = 1'b0;
      ram_we_o     = 1'b0;
      core_start_o = 1'b0;
      tx_start_o   = 1'b0;

      // Bytes arriving while not in LOAD are lost: flag an overrun.
      if (rx_rdy_i && (state_q != StLoad)) err_d = 1'b1;

      unique case (state_q)
         StLoad: begin
            if (rx_rdy_i) begin
               load    = 1'b1;
               state_d = StUnpack;
            end
         end
         StUnpack: begin
            ram_we_o = 1'b1;
            ram_d_o  = bit_out;
            shift    = 1'b1;
            wp_d     = wp_q + 10'd1;
            if (last) state_d = (wp_q == WpLast) ? StStart : StLoad;
         end
         StStart: begin
            core_start_o = 1'b1;
            timer_d      = '0;
            state_d      = StRun;
         end
         StRun: begin
            ram_addr_o = core_addr_i;
            timer_d    = timer_q + 1'b1;
            if (core_done_i) begin
               digit_d   = core_digit_i;
               tx_byte_d = digit_to_ascii(core_digit_i);
               state_d   = StSend;
            end else if (timer_q == TimerLast) begin
               err_d     = 1'b1;
               tx_byte_d = ASCII_ERR;
               state_d   = StSend;
            end
         end
         StSend: begin
            if (tx_rdy_i) begin
               tx_start_o = 1'b1;
               seen_low_d = 1'b0;
               state_d    = StWaitTx;
            end
         end
         StWaitTx: begin
            if (!tx_rdy_i) begin
               seen_low_d = 1'b1;
            end else if (seen_low_q) begin
               wp_d    = 10'd0;
               state_d = StLoad;
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StLoad;
         wp_q       <= 10'd0;
         timer_q    <= '0;
         digit_q    <= 4'd0;
         tx_byte_q  <= 8'd0;
         err_q      <= 1'b0;
         seen_low_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wp_q       <= wp_d;
         timer_q    <= timer_d;
         digit_q    <= digit_d;
         tx_byte_q  <= tx_byte_d;
         err_q      <= err_d;
         seen_low_q <= seen_low_d;
      end
   end

   assign tx_data_o = tx_byte_q;
   assign digit_o   = digit_q;
   assign busy_o    = (state_q != StLoad);
   assign err_o     = err_q;

endmodule

// File: tb/tb_snn_sequencer.sv
// Directed bench for snn_sequencer: frame unpack, result send, timeout, overrun, reset.
module tb_snn_sequencer;
   import snn_pkg::*;

   localparam int unsigned TIMEOUT = 32768;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_rdy = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       tx_rdy = 1'b1;
   logic       tx_start;
   logic [7:0] tx_data;
   logic [9:0] ram_addr;
   logic       ram_d;
   logic       ram_we;
   logic [9:0] core_addr = 10'd0;
   logic       core_start;
   logic       core_done = 1'b0;
   logic [3:0] core_digit = 4'd0;
   logic [3:0] digit;
   logic       busy;
   logic       err;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int exp_addr = 0;

   snn_sequencer #(
      .NUM_BYTES (98),
      .NUM_BITS  (NUM_BITS_C),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_rdy_i     (rx_rdy),
      .rx_data_i    (rx_data),
      .tx_rdy_i     (tx_rdy),
      .tx_start_o   (tx_start),
      .tx_data_o    (tx_data),
      .ram_addr_o   (ram_addr),
      .ram_d_o      (ram_d),
      .ram_we_o     (ram_we),
      .core_addr_i  (core_addr),
      .core_start_o (core_start),
      .core_done_i  (core_done),
      .core_digit_i (core_digit),
      .digit_o      (digit),
      .busy_o       (busy),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_we === 1'b1) wr_cnt <= wr_cnt + 1;

   function automatic logic [7:0] byte_of(input int k, input bit mode);
      logic [7:0] kb;
      kb = 8'(k * 37);
      return mode ? (kb ^ 8'h5A) : 8'hA5;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
      n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
      n_cmp++; if (ram_addr !== 10'd0) begin n_err++; $display("FAIL reset_ram_addr got %0d want 0", ram_addr); end
      n_cmp++; if (ram_d !== 1'b0) begin n_err++; $display("FAIL reset_ram_d got %b want 0", ram_d); end
      n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
      n_cmp++; if (core_start !== 1'b0) begin n_err++; $display("FAIL reset_core_start got %b want 0", core_start); end
      n_cmp++; if (digit !== 4'd0) begin n_err++; $display("FAIL reset_digit got %0d want 0", digit); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %b want 0", busy); end
   endtask

   // Pulses one byte and checks its eight writes. On the frame's last byte it
   // returns at the negedge of the core_start cycle; otherwise it pads to gap.
   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      rx_rdy = 1'b1;
      rx_data = b;
      @(negedge clk);
      rx_rdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (ram_we !== 1'b1 || ram_addr !== 10'(exp_addr) || ram_d !== b[i]) begin
            n_err++;
            $display("FAIL write got we=%b addr=%0d d=%b want we=1 addr=%0d d=%b",
                     ram_we, ram_addr, ram_d, exp_addr, b[i]);
         end
         exp_addr++;
         @(negedge clk);
      end
      n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL write_end got we=%b want 0", ram_we); end
      if (exp_addr == NUM_BITS_C) begin
         n_cmp++;
         if (core_start !== 1'b1) begin n_err++; $display("FAIL core_start got %b want 1", core_start); end
      end else begin
         n_cmp++;
         if (core_start !== 1'b0) begin n_err++; $display("FAIL core_start_early got %b want 0", core_start); end
         repeat (gap - 9) @(negedge clk);
      end
   endtask

   task automatic send_frame(input bit mode, input int gap);
      exp_addr = 0;
      for (int k = 0; k < 98; k++) send_byte(byte_of(k, mode), gap);
   endtask

   task automatic test_full_frame();
      send_frame(1'b0, 100);
      @(negedge clk);
      n_cmp++; if (core_start !== 1'b0) begin n_err++; $display("FAIL core_start_pulse got %b want 0", core_start); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL run_busy got %b want 1", busy); end
      core_addr = 10'h155;
      #1;
      n_cmp++; if (ram_addr !== 10'h155) begin n_err++; $display("FAIL core_addr_echo got %h want 155", ram_addr); end
      n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL run_we got %b want 0", ram_we); end
   endtask

   task automatic test_digit7();
      tx_rdy = 1'b1;
      core_done = 1'b1;
      core_digit = 4'd7;
      @(negedge clk);
      core_done = 1'b0;
      n_cmp++; if (digit !== 4'd7) begin n_err++; $display("FAIL d7_digit got %0d want 7", digit); end
      n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL d7_tx_start got %b want 1", tx_start); end
      n_cmp++; if (tx_data !== 8'h37) begin n_err++; $display("FAIL d7_tx_data got %h want 37", tx_data); end
      @(negedge clk);
      n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL d7_tx_once got %b want 0", tx_start); end
      tx_rdy = 1'b0;
      @(negedge clk);
      tx_rdy = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL d7_load got busy=%b want 0", busy); end
      n_cmp++; if (ram_addr !== 10'd0) begin n_err++; $display("FAIL d7_wp got %0d want 0", ram_addr); end
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL d7_err got %b want 0", err); end
   endtask

   task automatic test_digit12();
      send_frame(1'b1, 10);
      @(negedge clk);
      tx_rdy = 1'b0;
      core_done = 1'b1;
      core_digit = 4'd12;
      @(negedge clk);
      core_done = 1'b0;
      n_cmp++; if (digit !== 4'd12) begin n_err++; $display("FAIL d12_digit got %0d want 12", digit); end
      n_cmp++; if (tx_data !== 8'h3F) begin n_err++; $display("FAIL d12_tx_data got %h want 3F", tx_data); end
      repeat (3) @(negedge clk);
      n_cmp++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL d12_hold got tx_start=%b want 0", tx_start); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL d12_hold_busy got %b want 1", busy); end
      tx_rdy = 1'b1;
      #1;
      n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL d12_tx_start got %b want 1", tx_start); end
      @(negedge clk);
      tx_rdy = 1'b0;
      @(negedge clk);
      tx_rdy = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL d12_load got busy=%b want 0", busy); end
   endtask

   task automatic test_timeout();
      send_frame(1'b0, 10);
      tx_rdy = 1'b0;
      repeat (TIMEOUT) @(negedge clk);
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL to_early got err=%b want 0", err); end
      @(negedge clk);
      n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL to_err got %b want 1", err); end
      n_cmp++; if (tx_data !== 8'h45) begin n_err++; $display("FAIL to_tx_data got %h want 45", tx_data); end
      n_cmp++; if (digit !== 4'd12) begin n_err++; $display("FAIL to_digit got %0d want 12", digit); end
      core_done = 1'b1;
      core_digit = 4'd3;
      @(negedge clk);
      core_done = 1'b0;
      n_cmp++; if (digit !== 4'd12) begin n_err++; $display("FAIL to_late_done got %0d want 12", digit); end
      tx_rdy = 1'b1;
      #1;
      n_cmp++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL to_tx_start got %b want 1", tx_start); end
      @(negedge clk);
      tx_rdy = 1'b0;
      @(negedge clk);
      tx_rdy = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_load got busy=%b want 0", busy); end
   endtask

   task automatic test_done_outside_run();
      core_done = 1'b1;
      core_digit = 4'd5;
      @(negedge clk);
      core_done = 1'b0;
      n_cmp++; if (digit !== 4'd0) begin n_err++; $display("FAIL idle_done got digit=%0d want 0", digit); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_done got busy=%b want 0", busy); end
   endtask

   task automatic test_overrun();
      int w0;
      w0 = wr_cnt;
      @(negedge clk);
      rx_rdy = 1'b1;
      rx_data = 8'h3C;
      @(negedge clk);
      rx_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rx_rdy = 1'b1;
      rx_data = 8'hFF;
      @(negedge clk);
      rx_rdy = 1'b0;
      repeat (8) @(negedge clk);
      n_cmp++; if (wr_cnt - w0 !== 8) begin n_err++; $display("FAIL ovr_writes got %0d want 8", wr_cnt - w0); end
      n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL ovr_err got %b want 1", err); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_busy got %b want 0", busy); end
      n_cmp++; if (ram_addr !== 10'd8) begin n_err++; $display("FAIL ovr_wp got %0d want 8", ram_addr); end
      exp_addr = 8;
   endtask

   task automatic test_reset_midframe();
      for (int k = 1; k < 50; k++) send_byte(byte_of(k, 1'b1), 10);
      @(negedge clk);
      rx_rdy = 1'b1;
      rx_data = 8'h81;
      @(negedge clk);
      rx_rdy = 1'b0;
      @(negedge clk);
      test_reset();
   endtask

   task automatic test_fresh_frame();
      send_frame(1'b1, 10);
      @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fresh_busy got %b want 1", busy); end
      n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL fresh_err got %b want 0", err); end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_digit7();
      test_digit12();
      test_timeout();
      test_reset();
      test_done_outside_run();
      test_overrun();
      test_reset_midframe();
      test_fresh_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
